seven_seg_scan_ctrl: RTL
========================

Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for an N-digit common-anode seven-segment display. Holds a packed multi-digit BCD value and steps through the digits one at a time. For each digit it presents the 4-bit code on num, which drives the BCD-to-seven-segment decoder directly downstream, and asserts one active-low digit enable. New values arrive through a valid/ready handshake and take effect only on frame boundaries, so a displayed number never tears mid-frame.

Parameters:
NUM_DIGITS, 4, number of display digits (≥2); digit 0 is least significant.
REFRESH_DIV, 100000, clock cycles per digit slot (≥2).
BLANK_CYCLES, 1000, cycles at the start of each slot with all digits off, for anti-ghosting (0 ≤ BLANK_CYCLES < REFRESH_DIV).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
bcd_in  in  4*NUM_DIGITS  packed BCD value; nibble i = digit i
load_valid  in  1  bcd_in valid
load_ready  out  1  controller can accept a new value
num  out  4  current digit code, to the decoder
digit_sel  out  NUM_DIGITS  active-low digit enables; at most one bit low
frame_done  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Reset (async, rst_n=0):
  - state=BLANK, digit index=0, slot counter=0
  - display and pending registers = 0, pending flag = 0
  - num=4'h0, digit_sel=all 1s, load_ready=1, frame_done=0
- All outputs are registered.
- Slot counter:
  - width $clog2(REFRESH_DIV); counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, digit index increments modulo NUM_DIGITS.
- FSM:
  - BLANK: digit_sel all 1s; num = display nibble of the current index. Go to DRIVE when counter == BLANK_CYCLES-1.
  - DRIVE: digit_sel[index]=0, all other bits 1; num = same nibble. Return to BLANK on counter wrap.
  - BLANK_CYCLES=0: BLANK is never entered after reset; the first DRIVE starts on the cycle after reset release.
- Timing: per slot, exactly BLANK_CYCLES blank cycles, then REFRESH_DIV-BLANK_CYCLES drive cycles. Frame length = NUM_DIGITS*REFRESH_DIV cycles.
- frame_done: high for the single cycle in which counter = REFRESH_DIV-1 and index = NUM_DIGITS-1.
- Load handshake:
  - Transfer occurs when load_valid && load_ready at a rising edge: bcd_in is captured into the pending register, the pending flag is set, and load_ready=0 from the next cycle.
  - On the frame_done cycle with the pending flag set: pending moves to the display register and the flag clears. load_ready=1 the next cycle; the new value appears from digit 0 of the next frame.
  - A load accepted in the same cycle as frame_done is captured into pending but not transferred. It displays one frame later.
  - load_valid while load_ready=0 is ignored; bcd_in may change freely.
- Nibble values A–F pass through to num unmodified; the decoder defines their display.
- Async reset mid-slot: digit_sel goes to all 1s immediately. Any pending value is discarded.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined: during DRIVE, digit i (i ≥ 1) keeps digit_sel all 1s when it and every more-significant display nibble equal 0. Digit 0 is never suppressed. Slot timing and num are unchanged.
- Undefined: every digit is driven in its slot.

Decomposition:
- Shared package seven_seg_pkg:
  - state enum {BLANK, DRIVE}
  - BCD_W=4
  - DIGIT_OFF constant (all 1s)
  - function returning the one-hot-low select for an index
- One natural sub-module: seven_seg_slot_timer (slot counter + digit index + frame_done). The FSM, handshake and blanking stay in the top.

Test Plan:
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
1. Reset, then release with no load -> digit_sel=4'b1111 for 2 cycles, then 4'b1110 for 6 cycles with num=0. frame_done pulses every 32 cycles.
2. Load 16'h1234 at cycle 5 -> load_ready=0 from cycle 6 until the cycle after frame_done. The next frame shows num 4,3,2,1 with digit_sel 1110,1101,1011,0111, each low 6 of 8 cycles.
3. Load asserted on the frame_done cycle, then a second load attempted while load_ready=0 -> first value shown one frame late; second value not accepted.
4. rst_n dropped mid-DRIVE of digit 2 -> digit_sel=4'b1111 within the same cycle. After release, the display register is 0 and the scan restarts at digit 0 in BLANK.
5. With the macro defined, load 16'h0050 -> digits 3 and 2 stay off; digit 1 shows 5 and digit 0 shows 0. Without the macro, all four digits are driven (0,5,0,0).
6. BLANK_CYCLES=0 -> first DRIVE on the cycle after reset release, and exactly one digit_sel bit low in every cycle thereafter.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types, constants and select helper for the seven-segment scan controller.
package seven_seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 32;

  localparam logic [MAX_DIGITS-1:0] DIGIT_OFF = '1;

  // Active-low one-hot select; callers truncate to their digit count.
  function automatic logic [MAX_DIGITS-1:0] digit_sel_low(input int unsigned idx);
    return ~(MAX_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seven_seg_slot_timer.sv
// Slot counter, digit index and end-of-frame pulse for the scan controller.
module seven_seg_slot_timer
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = $clog2(REFRESH_DIV),
  parameter int IDX_W       = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_wrap,
  output logic [IDX_W-1:0] o_idx_nxt,
  output logic             o_frame_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_frame_done;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_wrap;

  always_comb begin
    w_wrap    = (r_cnt == CNT_LAST);
    w_cnt_nxt = w_wrap ? '0 : r_cnt + CNT_W'(1);
    w_idx_nxt = r_idx;
    if (w_wrap) begin
      w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end
  end

  // frame_done is registered from the next-cycle position so it lines up
  // with the cycle in which the counter sits at its last value of the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_frame_done <= (w_cnt_nxt == CNT_LAST) && (w_idx_nxt == IDX_LAST);
    end
  end

  assign o_cnt        = r_cnt;
  assign o_wrap       = w_wrap;
  assign o_idx_nxt    = w_idx_nxt;
  assign o_frame_done = r_frame_done;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment scan controller with frame-aligned loads.
// Optional leading-zero suppression: define SEVEN_SEG_LEADING_ZERO_BLANK_EN.
//
//   state | meaning
//   BLANK | all digits off (anti-ghosting) at the start of a slot
//   DRIVE | current digit enabled until the slot counter wraps
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
  input  logic                        load_valid,
  output logic                        load_ready,
  output logic [BCD_W-1:0]            num,
  output logic [NUM_DIGITS-1:0]       digit_sel,
  output logic                        frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_BLANK_LAST =
    CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

  scan_state_t r_state, w_state_nxt;

  logic [NUM_DIGITS-1:0][BCD_W-1:0] r_disp, r_pend_val, w_disp_nxt;
  logic                             r_pend, r_load_ready;
  logic [BCD_W-1:0]                 r_num, w_num_nxt;
  logic [NUM_DIGITS-1:0]            r_digit_sel, w_sel_nxt;

  logic [CNT_W-1:0] w_cnt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_wrap, w_frame_done;
  logic             w_accept, w_commit, w_suppress;

  seven_seg_slot_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W),
    .IDX_W       (IDX_W)
  ) u_slot_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_cnt        (w_cnt),
    .o_wrap       (w_wrap),
    .o_idx_nxt    (w_idx_nxt),
    .o_frame_done (w_frame_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BLANK;
    else        r_state <= w_state_nxt;
  end

  assign w_accept   = load_valid && r_load_ready;
  assign w_commit   = w_frame_done && r_pend;
  assign w_disp_nxt = w_commit ? r_pend_val : r_disp;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_upper_zero;

  always_comb begin
    logic zacc;
    zacc         = 1'b1;
    w_upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zacc            = zacc & (w_disp_nxt[i] == '0);
      w_upper_zero[i] = zacc;
    end
    w_suppress = (w_idx_nxt != '0) && w_upper_zero[w_idx_nxt];
  end
`else
  assign w_suppress = 1'b0;
`endif

  // Outputs are registered from next-cycle state and index so each output
  // cycle reflects the slot position the counter holds in that same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BLANK:   if (BLANK_CYCLES == 0 || w_cnt == CNT_BLANK_LAST) w_state_nxt = DRIVE;
      DRIVE:   if (BLANK_CYCLES != 0 && w_wrap) w_state_nxt = BLANK;
      default: w_state_nxt = BLANK;
    endcase
    w_num_nxt = w_disp_nxt[w_idx_nxt];
    w_sel_nxt = NUM_DIGITS'(DIGIT_OFF);
    if (w_state_nxt == DRIVE && !w_suppress) begin
      w_sel_nxt = NUM_DIGITS'(digit_sel_low(32'(w_idx_nxt)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp       <= '0;
      r_pend_val   <= '0;
      r_pend       <= 1'b0;
      r_load_ready <= 1'b1;
      r_num        <= '0;
      r_digit_sel  <= NUM_DIGITS'(DIGIT_OFF);
    end else begin
      r_disp      <= w_disp_nxt;
      r_num       <= w_num_nxt;
      r_digit_sel <= w_sel_nxt;
      if (w_accept) begin
        r_pend_val   <= bcd_in;
        r_pend       <= 1'b1;
        r_load_ready <= 1'b0;
      end else if (w_commit) begin
        r_pend       <= 1'b0;
        r_load_ready <= 1'b1;
      end
    end
  end

  assign load_ready = r_load_ready;
  assign num        = r_num;
  assign digit_sel  = r_digit_sel;
  assign frame_done = w_frame_done;

endmodule
